// File: rtl/icache_axi_rd_if.sv
// AXI4 read-address and read-data channels seen by the icache bridge.
// The master modport is the bridge, the slave modport is the memory side.
interface icache_axi_rd_if #(
    parameter int A_WIDTH = 32
);
    logic [3:0]         arid;
    logic [A_WIDTH-1:0] araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic [1:0]         arlock;
    logic [3:0]         arcache;
    logic [2:0]         arprot;
    logic               arvalid;
    logic               arready;
    logic [3:0]         rid;
    logic [31:0]        rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/icache_axi_rd.sv
// Icache miss port to single-beat AXI4 read bridge, one read in flight.
// A fill is dropped if the cache moved to another address meanwhile.
module icache_axi_rd #(
    parameter int         A_WIDTH = 32,
    parameter logic [3:0] AXI_ID  = 4'd0
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] m_a,
    input  logic               m_strobe,
    output logic [31:0]        m_dout,
    output logic               m_ready,
    output logic               m_err,
    icache_axi_rd_if.master    axi
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t             r_state;
    logic [A_WIDTH-3:0] r_req_addr;
    logic [31:0]        r_dout;
    logic               r_err;
    logic               r_arvalid;
    logic               r_rready;

    logic               w_r_hs;
    logic               w_hit;
    logic               w_unused;

    assign w_r_hs = axi.rvalid & r_rready;

    // Request FSM; AXI valid/ready outputs are flops set on transitions
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= IDLE;
            r_req_addr <= '0;
            r_dout     <= '0;
            r_err      <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (m_strobe) begin
                        r_req_addr <= m_a[A_WIDTH-1:2];
                        r_arvalid  <= 1'b1;
                        r_state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_hs) begin
                        r_dout   <= axi.rdata;
                        r_err    <= axi.rresp[1];
                        r_rready <= 1'b0;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Deliver only if the cache still wants the word we fetched
    assign w_hit = (r_state == RESP) & m_strobe &
                   (m_a[A_WIDTH-1:2] == r_req_addr);

    assign m_ready = w_hit;
    assign m_dout  = r_dout;
    assign m_err   = r_err & w_hit;

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = {r_req_addr, 2'b00};
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

    // Single-beat reads: id, last and the low response bit carry nothing
    assign w_unused = ^{axi.rid, axi.rlast, axi.rresp[0], m_a[1:0]};

endmodule
